// File: rtl/cover_toggle_drain.sv
// Toggle-coverage drain: captures per-point toggle hits into a pending set and
// reports each point exactly once, round-robin, over a valid/ready handshake.
module cover_toggle_drain #(
    parameter int unsigned     WIDTH       = 62,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int unsigned     IDX_W       = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           out_index,
    output logic [$clog2(WIDTH+1)-1:0] covered_count,
    output logic                       all_covered
);

    localparam int unsigned PTR_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] covered;
    logic [PTR_W-1:0] rr_ptr;

    logic [WIDTH-1:0] pending_nxt;
    logic [WIDTH-1:0] covered_nxt;
    logic [PTR_W-1:0] rr_ptr_nxt;
    logic             out_valid_nxt;
    logic [IDX_W-1:0] out_index_nxt;
    logic [CNT_W-1:0] count_nxt;

    logic             xfer;
    logic             load;
    logic             found;
    logic [PTR_W-1:0] sel;
    logic [PTR_W:0]   cand;
    logic [WIDTH-1:0] load_mask;
    logic [WIDTH-1:0] capture;

    // Rotating-priority search: first pending bit at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(WIDTH)) begin
                cand = cand - (PTR_W + 1)'(WIDTH);
            end
            if (!found && pending[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[PTR_W-1:0];
            end
        end
    end

    // Next-state: capture, slot load, handshake and clear handling.
    always_comb begin
        xfer          = out_valid && out_ready;
        load          = (!out_valid || out_ready) && (pending != '0) && !clear;
        load_mask     = load ? (WIDTH'(1) << sel) : '0;
        capture       = '0;
        pending_nxt   = pending;
        covered_nxt   = covered;
        rr_ptr_nxt    = rr_ptr;
        out_valid_nxt = out_valid;
        out_index_nxt = out_index;
        count_nxt     = covered_count;

        if (clear) begin
            // Slot survives a clear; only a transfer on this edge empties it.
            pending_nxt = '0;
            covered_nxt = '0;
            count_nxt   = '0;
            if (xfer) begin
                out_valid_nxt = 1'b0;
            end
        end else begin
            if (xfer && (covered_count < CNT_W'(WIDTH))) begin
                count_nxt = covered_count + CNT_W'(1);
            end
            if (enable) begin
                capture = valid & ~covered & ~pending & ~load_mask;
            end
            pending_nxt = (pending & ~load_mask) | capture;
            covered_nxt = covered | load_mask;
            if (load) begin
                out_valid_nxt = 1'b1;
                out_index_nxt = IDX_W'(COVER_INDEX) + IDX_W'(sel);
                rr_ptr_nxt    = (sel == PTR_W'(WIDTH - 1)) ? '0 : sel + PTR_W'(1);
            end else if (xfer) begin
                out_valid_nxt = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending       <= '0;
            covered       <= '0;
            rr_ptr        <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
            covered_count <= '0;
            all_covered   <= 1'b0;
        end else begin
            pending       <= pending_nxt;
            covered       <= covered_nxt;
            rr_ptr        <= rr_ptr_nxt;
            out_valid     <= out_valid_nxt;
            out_index     <= out_index_nxt;
            covered_count <= count_nxt;
            all_covered   <= (count_nxt == CNT_W'(WIDTH));
        end
    end

endmodule

// File: tb/tb_cover_toggle_drain.sv
// Bench for cover_toggle_drain: directed scenarios plus random traffic, each
// cycle compared against an array-based reference model.
module tb_cover_toggle_drain;

    localparam int unsigned     WIDTH = 62;
    localparam longint unsigned CI    = 100;
    localparam int unsigned     IDX_W = 64;
    localparam int unsigned     CNT_W = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] valid;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [CNT_W-1:0] covered_count;
    logic             all_covered;

    cover_toggle_drain #(.WIDTH(WIDTH), .COVER_INDEX(CI), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .valid(valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .covered_count(covered_count),
        .all_covered(all_covered)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    // Reference model state
    bit              m_pend [WIDTH];
    bit              m_cov  [WIDTH];
    int              m_rr;
    bit              m_ov;
    longint unsigned m_idx;
    int              m_cnt;

    longint unsigned xq[$];
    int              cq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_update(input bit rst, input bit en, input bit clr, input bit rdy,
                                input logic [WIDTH-1:0] v);
        bit xf, ld, any;
        int b;
        bit hit [WIDTH];
        if (!rst) begin
            foreach (m_pend[i]) begin m_pend[i] = 0; m_cov[i] = 0; end
            m_rr = 0; m_ov = 0; m_idx = 0; m_cnt = 0;
            return;
        end
        xf = m_ov && rdy;
        if (clr) begin
            foreach (m_pend[i]) begin m_pend[i] = 0; m_cov[i] = 0; end
            m_cnt = 0;
            if (xf) m_ov = 0;
            return;
        end
        if (xf && m_cnt < WIDTH) m_cnt++;
        any = 0; b = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!any && m_pend[(m_rr + k) % WIDTH]) begin
                any = 1; b = (m_rr + k) % WIDTH;
            end
        end
        ld = (!m_ov || rdy) && any;
        foreach (hit[i]) hit[i] = en && v[i] && !m_cov[i] && !m_pend[i] && !(ld && i == b);
        if (ld) begin
            m_pend[b] = 0; m_cov[b] = 1;
            m_idx = CI + longint'(b); m_ov = 1; m_rr = (b + 1) % WIDTH;
        end else if (xf) begin
            m_ov = 0;
        end
        foreach (hit[i]) if (hit[i]) m_pend[i] = 1;
    endtask

    task automatic step(input bit rst, input bit en, input bit clr, input bit rdy,
                        input logic [WIDTH-1:0] v);
        reset = rst; enable = en; clear = clr; out_ready = rdy; valid = v;
        if (rst && out_valid && rdy) begin
            xq.push_back(out_index);
            cq.push_back(cycle);
        end
        @(posedge clock);
        cycle++;
        model_update(rst, en, clr, rdy, v);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("out_index", out_index, m_idx);
        check("covered_count", 64'(covered_count), 64'(m_cnt));
        check("all_covered", 64'(all_covered), 64'(m_cnt == WIDTH));
    endtask

    function automatic logic [WIDTH-1:0] bitv(input int b);
        return WIDTH'(1) << b;
    endfunction

    initial begin
        logic [WIDTH-1:0] v;
        reset = 0; enable = 0; clear = 0; out_ready = 0; valid = '0;

        // 1: single hit, two-edge latency
        step(0, 1, 0, 1, '0);
        step(0, 1, 0, 1, '0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(covered_count), 64'd0);
        step(1, 1, 0, 1, bitv(5));
        check("t1_latency", 64'(out_valid), 64'd0);
        step(1, 1, 0, 1, '0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_index", out_index, 64'd105);
        step(1, 1, 0, 1, '0);
        check("t1_count", 64'(covered_count), 64'd1);

        // 2: all points, full throughput, ascending
        step(0, 1, 0, 1, '0);
        xq.delete(); cq.delete();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, '1);
        for (int i = 0; i < 70; i++) step(1, 1, 0, 1, '0);
        check("t2_transfers", 64'(xq.size()), 64'(WIDTH));
        if (xq.size() == WIDTH) begin
            for (int k = 0; k < WIDTH; k++) check("t2_order", xq[k], CI + 64'(k));
            check("t2_no_bubbles", 64'(cq[WIDTH-1] - cq[0]), 64'(WIDTH - 1));
        end
        check("t2_all_covered", 64'(all_covered), 64'd1);
        check("t2_idle", 64'(out_valid), 64'd0);

        // 3: backpressure holds the slot
        step(0, 1, 0, 0, '0);
        step(1, 1, 0, 0, bitv(3));
        step(1, 1, 0, 0, '0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0, (i % 2 == 1) ? bitv(7) : bitv(3));
            check("t3_hold", out_index, 64'd103);
        end
        xq.delete();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, '0);
        check("t3_count", 64'(xq.size()), 64'd2);
        if (xq.size() == 2) begin
            check("t3_first", xq[0], 64'd103);
            check("t3_second", xq[1], 64'd107);
        end

        // 4: round-robin wrap from the last point
        step(0, 1, 0, 1, '0);
        step(1, 1, 0, 1, bitv(60));
        step(1, 1, 0, 1, '0);
        step(1, 1, 0, 1, '0);
        xq.delete();
        step(1, 1, 0, 1, bitv(61) | bitv(0));
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, '0);
        check("t4_count", 64'(xq.size()), 64'd2);
        if (xq.size() == 2) begin
            check("t4_first", xq[0], 64'd161);
            check("t4_second", xq[1], 64'd100);
        end
        check("t4_rr_ptr", 64'(dut.rr_ptr), 64'd1);

        // 5: clear with an occupied slot
        step(0, 1, 0, 0, '0);
        step(1, 1, 0, 0, bitv(10));
        step(1, 1, 0, 0, '0);
        step(1, 1, 1, 0, '0);
        check("t5_slot_kept", out_index, 64'd110);
        check("t5_clear_count", 64'(covered_count), 64'd0);
        xq.delete();
        step(1, 1, 0, 1, '0);
        check("t5_count_after", 64'(covered_count), 64'd1);
        step(1, 1, 0, 1, bitv(10));
        step(1, 1, 0, 1, '0);
        step(1, 1, 0, 1, '0);
        check("t5_rehit", 64'(xq.size()), 64'd2);
        if (xq.size() == 2) check("t5_rehit_index", xq[1], 64'd110);

        // 6: enable gating and reset mid-transfer
        step(0, 1, 0, 1, '0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, '1);
            check("t6_disabled", 64'(out_valid), 64'd0);
        end
        step(1, 1, 0, 0, bitv(2));
        step(1, 1, 0, 0, '0);
        check("t6_loaded", 64'(out_valid), 64'd1);
        step(0, 1, 0, 1, '0);
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_count", 64'(covered_count), 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            v = '0;
            if ($urandom_range(0, 49) == 0) v = '1;
            else begin
                int nb;
                nb = $urandom_range(0, 3);
                for (int j = 0; j < nb; j++) v[$urandom_range(0, WIDTH - 1)] = 1'b1;
            end
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, v);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
